write_to_ddr3: RTL
==================

# write_to_ddr3

Frame writer that drains pixel words from a show-ahead input FIFO into one of two DDR3 frame buffers using 4-beat Avalon-MM write bursts. It sits directly upstream of the DDR3 frame reader and owns the two buffer-empty flags that the reader consumes. The reader releases a displayed buffer with a clear pulse, and this block then refills it. Double buffering alternates between buffer 0 and buffer 1.

## Interface
- IMAGE_WIDTH, 1280, pixels per line (one pixel = one Avalon word)
- IMAGE_HEIGHT, 1024, lines per frame; IMAGE_WIDTH*IMAGE_HEIGHT must be a multiple of 4
- DATA_WIDTH, 32, Avalon data width
- BUFFER0_BASE, 26'h0000000, word address of buffer 0
- BUFFER1_BASE, 26'h0200000, word address of buffer 1
- ddr3_clk  in  1  sole clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- pix_fifo_rdata  in  DATA_WIDTH  head word of show-ahead pixel FIFO
- pix_fifo_usedw  in  10  words held in pixel FIFO
- pix_fifo_rdreq  out  1  pop; combinational = ddr3_avl_write_req & ddr3_avl_ready
- ddr3_rd_buffer0_empty  out  1  1 = buffer 0 holds no complete frame
- ddr3_rd_buffer1_empty  out  1  same for buffer 1
- clear_buffer0  in  1  reader releases buffer 0; rising edge is the event
- clear_buffer1  in  1  same for buffer 1
- ddr3_buffer0_offset  out  26  constant BUFFER0_BASE
- ddr3_buffer1_offset  out  26  constant BUFFER1_BASE
- ddr3_avl_ready  in  1  controller accepts current beat
- ddr3_avl_burstbegin  out  1  first beat of burst
- ddr3_avl_size  out  3  constant 3'b100
- ddr3_avl_write_req  out  1  write beat valid
- ddr3_avl_addr  out  26  burst start word address
- ddr3_avl_wdata  out  DATA_WIDTH  combinational = pix_fifo_rdata

## Operation
- Constants: NBURST = IMAGE_WIDTH*IMAGE_HEIGHT/4. The burst counter is 24 bits, the beat counter is 2 bits, and the target-buffer select is 1 bit (reset 0).
- WAIT_BUF: wait until the target buffer's empty flag is 1. Then load addr = target base, burst_cnt = 0, and go to WAIT_DATA.
- WAIT_DATA: when pix_fifo_usedw >= 4, register write_req = 1 and burstbegin = 1, then go to BURST.
- BURST: write_req is held high for exactly 4 accepted beats. A beat is accepted in a cycle with write_req & ready.
  - burstbegin stays 1 until the first beat is accepted, then drops to 0 for beats 2-4.
  - addr is held constant for the whole burst.
  - If ready = 0, the beat is held: data, req and addr are stable and no pop occurs.
- End of burst, when the 4th beat is accepted:
  - If burst_cnt != NBURST-1: increment burst_cnt, addr += 4, deassert req, go to WAIT_DATA.
  - Otherwise (frame done): drive the target buffer's empty flag to 0, toggle the target, go to WAIT_BUF.
- Clear event: clear_bufferN is 1 now and was 0 last cycle (a registered previous value is kept per input). The event sets ddr3_rd_bufferN_empty to 1. A clear held high has no further effect.
- Simultaneous frame-done set and clear event on the same buffer: the set wins (flag goes to 0).
- The writer never writes a buffer whose empty flag is 0. It stalls in WAIT_BUF, and the upstream FIFO absorbs or drops data.

## Timing
- Reset values:
  - state WAIT_BUF, target 0, burst_cnt 0, beat 0
  - ddr3_avl_addr 0, ddr3_avl_write_req 0, ddr3_avl_burstbegin 0
  - ddr3_rd_buffer0_empty 1, ddr3_rd_buffer1_empty 1, clear-edge registers 0
- Idle-to-first-beat latency: WAIT_BUF exit takes 1 cycle and WAIT_DATA to req high takes 1 cycle. The first beat is presented 2 cycles after the target buffer is empty, given usedw >= 4.
- Back-to-back bursts with ready = 1 and a full FIFO: 4 beat cycles plus 1 WAIT_DATA cycle, so 5 cycles per burst.
- Empty-flag update is registered, visible the cycle after the final beat is accepted. Clear-event update is also registered, visible one cycle after the clear rising edge.
- Reset asserted mid-burst: immediate return to reset values. The partial frame is abandoned and both buffers read as empty.

## Test plan
- IMAGE_WIDTH=8, IMAGE_HEIGHT=2, ready = 1, FIFO holding words 0..15 -> 4 bursts:
  - addr 0, 4, 8, 12
  - burstbegin only on beats 0, 4, 8, 12
  - 16 pops
  - buffer0_empty falls to 0 the cycle after beat 15
- ready toggling 1,0 per cycle mid-burst -> wdata, addr and req held while ready = 0; exactly 4 pops per burst; no duplicated or lost word.
- Two frames with buffer0 never cleared -> frame 2 lands at BUFFER1_BASE+0..15 and buffer1_empty = 0. Frame 3 stalls in WAIT_BUF (req 0) until a clear_buffer0 rising edge, then writes at BUFFER0_BASE.
- clear_buffer1 held high for 100 cycles -> buffer1_empty set once. A later frame into buffer1 sets the flag to 0, and it stays 0 despite clear still high.
- usedw = 3 -> no request. usedw goes to 4 -> req asserted 1 cycle later.
- reset_n pulsed low after 6 accepted beats -> outputs at reset values asynchronously. After release, writing restarts at BUFFER0_BASE with both flags = 1.

Source files
------------

// File: rtl/write_to_ddr3.sv
// write_to_ddr3
// Drains pixel words from a show-ahead FIFO into one of two DDR3 frame
// buffers using 4-beat Avalon-MM write bursts, alternating buffers per frame.
// Owns the per-buffer "empty" flags consumed by the frame reader. The reader
// releases a buffer with a rising edge on clear_bufferN.
//
// Ports
//   ddr3_clk, reset_n         : clock, asynchronous active-low reset
//   pix_fifo_rdata/usedw      : head word and fill level of pixel FIFO
//   pix_fifo_rdreq            : FIFO pop (accepted beat)
//   ddr3_rd_bufferN_empty     : 1 = buffer N holds no complete frame
//   clear_bufferN             : reader release request (rising edge)
//   ddr3_bufferN_offset       : constant buffer base word addresses
//   ddr3_avl_*                : Avalon-MM burst write master
module write_to_ddr3 #(
    parameter int          IMAGE_WIDTH  = 1280,
    parameter int          IMAGE_HEIGHT = 1024,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [25:0] BUFFER0_BASE = 26'h0000000,
    parameter logic [25:0] BUFFER1_BASE = 26'h0200000
) (
    input  logic                  ddr3_clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] pix_fifo_rdata,
    input  logic [9:0]            pix_fifo_usedw,
    output logic                  pix_fifo_rdreq,
    output logic                  ddr3_rd_buffer0_empty,
    output logic                  ddr3_rd_buffer1_empty,
    input  logic                  clear_buffer0,
    input  logic                  clear_buffer1,
    output logic [25:0]           ddr3_buffer0_offset,
    output logic [25:0]           ddr3_buffer1_offset,
    input  logic                  ddr3_avl_ready,
    output logic                  ddr3_avl_burstbegin,
    output logic [2:0]            ddr3_avl_size,
    output logic                  ddr3_avl_write_req,
    output logic [25:0]           ddr3_avl_addr,
    output logic [DATA_WIDTH-1:0] ddr3_avl_wdata
);

    localparam int          NBURST     = (IMAGE_WIDTH * IMAGE_HEIGHT) / 4;
    localparam logic [23:0] LAST_BURST = 24'(NBURST - 1);

    typedef enum logic [1:0] {
        WAIT_BUF  = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2
    } state_t;

    state_t      state_q;
    logic        target_q;
    logic [23:0] burst_cnt_q;
    logic [1:0]  beat_q;
    logic [25:0] addr_q;
    logic        req_q;
    logic        bb_q;
    logic        empty0_q;
    logic        empty1_q;
    logic        clr0_prev_q;
    logic        clr1_prev_q;

    logic        accept;
    logic        clr0_evt;
    logic        clr1_evt;
    logic        target_empty;

    assign accept       = req_q & ddr3_avl_ready;
    assign clr0_evt     = clear_buffer0 & ~clr0_prev_q;
    assign clr1_evt     = clear_buffer1 & ~clr1_prev_q;
    assign target_empty = target_q ? empty1_q : empty0_q;

    assign pix_fifo_rdreq        = accept;
    assign ddr3_avl_wdata        = pix_fifo_rdata;
    assign ddr3_avl_write_req    = req_q;
    assign ddr3_avl_burstbegin   = bb_q;
    assign ddr3_avl_addr         = addr_q;
    assign ddr3_avl_size         = 3'b100;
    assign ddr3_rd_buffer0_empty = empty0_q;
    assign ddr3_rd_buffer1_empty = empty1_q;
    assign ddr3_buffer0_offset   = BUFFER0_BASE;
    assign ddr3_buffer1_offset   = BUFFER1_BASE;

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_BUF;
            target_q    <= 1'b0;
            burst_cnt_q <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            req_q       <= 1'b0;
            bb_q        <= 1'b0;
            empty0_q    <= 1'b1;
            empty1_q    <= 1'b1;
            clr0_prev_q <= 1'b0;
            clr1_prev_q <= 1'b0;
        end else begin
            clr0_prev_q <= clear_buffer0;
            clr1_prev_q <= clear_buffer1;

            // Clear events first; a frame-done clear below overrides them
            // on the same buffer, so the freshly written frame is not lost.
            if (clr0_evt) empty0_q <= 1'b1;
            if (clr1_evt) empty1_q <= 1'b1;

            case (state_q)
                WAIT_BUF: begin
                    if (target_empty) begin
                        addr_q      <= target_q ? BUFFER1_BASE : BUFFER0_BASE;
                        burst_cnt_q <= '0;
                        state_q     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    // Only start a burst when all four beats are already
                    // available, so the burst never stalls on the FIFO.
                    if (pix_fifo_usedw >= 10'd4) begin
                        req_q   <= 1'b1;
                        bb_q    <= 1'b1;
                        beat_q  <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        bb_q   <= 1'b0;
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            req_q <= 1'b0;
                            if (burst_cnt_q != LAST_BURST) begin
                                burst_cnt_q <= burst_cnt_q + 24'd1;
                                addr_q      <= addr_q + 26'd4;
                                state_q     <= WAIT_DATA;
                            end else begin
                                if (target_q) empty1_q <= 1'b0;
                                else          empty0_q <= 1'b0;
                                target_q <= ~target_q;
                                state_q  <= WAIT_BUF;
                            end
                        end
                    end
                end
                default: state_q <= WAIT_BUF;
            endcase
        end
    end

endmodule
